qspi_flash_responder: RTL and testbench

Synthesizable QSPI NOR-flash responder for the Verilator SoC bench. It attaches to the `soc_top` QSPI initiator pins, serving the `peripheral_qspi_*` group, in place of a constant-zero tie-off. It decodes the command, address and dummy phases and returns bytes from an internal byte array. The array is preloaded through a backdoor write port. The whole block runs in the bench `clk_i` domain and detects SCLK edges by oversampling.

---
 rtl/qspi_flash_responder.sv | 200 ++++++++++++++++++++
 tb/tb_qspi_flash_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder
//   Oversampled QSPI NOR-flash responder for the SoC bench. It decodes a
//   command byte, an address and optional dummy cycles, all on IO0. It then
//   streams bytes from an internal array, which is preloaded through a
//   backdoor write port.
//   Supported commands:
//     0x03 = single-bit read, data on IO1.
//     0x6B = quad read, data on IO[3:0] after DUMMY_CYCLES dummy clocks.
//   Any other command sets the sticky err_o and is ignored until CS rises.
//
// Ports
//   clk_i, reset_ni  : bench clock; synchronous active-low reset
//   qspi_sclk_i      : SCLK, mode 0 (idle low); oversampled by clk_i
//   qspi_cs_ni       : chip select, active low
//   qspi_data_i      : IO[3:0] from initiator (IO0 = MOSI)
//   qspi_data_o      : IO[3:0] to initiator
//   qspi_data_oe_o   : 1 while the responder drives qspi_data_o
//   mem_we_i/addr/wdata : backdoor byte write into the array
//   err_o            : sticky unsupported-command flag, cleared by reset only
module qspi_flash_responder #(
    parameter int MEM_BYTES    = 4096,
    parameter int ADDR_W       = 24,
    parameter int DUMMY_CYCLES = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         qspi_sclk_i,
    input  logic                         qspi_cs_ni,
    input  logic [3:0]                   qspi_data_i,
    output logic [3:0]                   qspi_data_o,
    output logic                         qspi_data_oe_o,
    input  logic                         mem_we_i,
    input  logic [$clog2(MEM_BYTES)-1:0] mem_addr_i,
    input  logic [7:0]                   mem_wdata_i,
    output logic                         err_o
);
    localparam int IDX_W   = $clog2(MEM_BYTES);
    localparam int CNT_MAX = (ADDR_W > DUMMY_CYCLES) ?
                             ((ADDR_W > 8) ? ADDR_W : 8) :
                             ((DUMMY_CYCLES > 8) ? DUMMY_CYCLES : 8);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_QREAD = 8'h6B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_IGNORE
    } state_t;

    logic [7:0]               mem [MEM_BYTES];

    state_t                   state;
    logic                     sclk_q;
    logic                     rise;
    logic                     fall;
    logic                     quad;
    logic [CNT_W-1:0]         bit_cnt;
    logic [6:0]               cmd_sh;
    logic [ADDR_W-2:0]        addr_sh;
    logic [IDX_W-1:0]         idx;
    logic [7:0]               out_sh;
    logic [2:0]               out_cnt;

    logic                     mosi;
    logic [7:0]               cmd_next;
    logic [ADDR_W-1:0]        addr_next;
    logic [ADDR_W+IDX_W-1:0]  addr_ext;
    logic [7:0]               cur;
    logic                     byte_start;
    logic                     byte_last;
    logic                     unused_bits;

    assign rise      = qspi_sclk_i & ~sclk_q;
    assign fall      = ~qspi_sclk_i & sclk_q;
    assign mosi      = qspi_data_i[0];
    assign cmd_next  = {cmd_sh, mosi};
    assign addr_next = {addr_sh, mosi};
    // Zero-extend so the modulo slice below is legal for any ADDR_W/IDX_W mix.
    assign addr_ext  = {{IDX_W{1'b0}}, addr_next};

    // The byte at the head of a byte slot comes straight from the array.
    // Later slots shift out of out_sh. A backdoor write after the load
    // therefore cannot disturb the byte being sent.
    assign byte_start = (out_cnt == 3'd0);
    assign byte_last  = quad ? (out_cnt == 3'd1) : (out_cnt == 3'd7);
    assign cur        = byte_start ? mem[idx] : out_sh;

    assign unused_bits = ^{qspi_data_i[3:1], addr_ext};

    // Backdoor port. The array has no reset, so its contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_i) begin
            mem[mem_addr_i] <= mem_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state          <= S_IDLE;
            sclk_q         <= 1'b0;
            quad           <= 1'b0;
            bit_cnt        <= '0;
            cmd_sh         <= '0;
            addr_sh        <= '0;
            idx            <= '0;
            out_sh         <= '0;
            out_cnt        <= '0;
            qspi_data_o    <= 4'h0;
            qspi_data_oe_o <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            sclk_q <= qspi_sclk_i;
            // CS high overrides everything, including an SCLK edge seen on
            // the same clock.
            if (qspi_cs_ni) begin
                state          <= S_IDLE;
                bit_cnt        <= '0;
                out_cnt        <= '0;
                qspi_data_o    <= 4'h0;
                qspi_data_oe_o <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state   <= S_CMD;
                        bit_cnt <= '0;
                    end

                    S_CMD: if (rise) begin
                        cmd_sh <= cmd_next[6:0];
                        if (bit_cnt == CNT_W'(7)) begin
                            bit_cnt <= '0;
                            if (cmd_next == CMD_READ) begin
                                quad  <= 1'b0;
                                state <= S_ADDR;
                            end else if (cmd_next == CMD_QREAD) begin
                                quad  <= 1'b1;
                                state <= S_ADDR;
                            end else begin
                                err_o <= 1'b1;
                                state <= S_IGNORE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end

                    S_ADDR: if (rise) begin
                        addr_sh <= addr_next[ADDR_W-2:0];
                        if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
                            bit_cnt <= '0;
                            out_cnt <= '0;
                            // Upper address bits are ignored.
                            idx     <= addr_ext[IDX_W-1:0];
                            state   <= (quad && DUMMY_CYCLES > 0) ? S_DUMMY : S_DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end

                    S_DUMMY: if (rise) begin
                        if (bit_cnt == CNT_W'(DUMMY_CYCLES - 1)) begin
                            bit_cnt <= '0;
                            state   <= S_DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end

                    S_DATA: if (fall) begin
                        qspi_data_oe_o <= 1'b1;
                        if (quad) begin
                            qspi_data_o <= cur[7:4];
                            out_sh      <= {cur[3:0], 4'h0};
                        end else begin
                            qspi_data_o <= {2'b00, cur[7], 1'b0};
                            out_sh      <= {cur[6:0], 1'b0};
                        end
                        // The power-of-two depth gives the wrap from
                        // MEM_BYTES-1 to 0 for free.
                        if (byte_start) begin
                            idx <= idx + 1'b1;
                        end
                        out_cnt <= byte_last ? 3'd0 : out_cnt + 3'd1;
                    end

                    S_IGNORE: begin
                        // Hold until CS rises. The outputs stay undriven.
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qspi_flash_responder.sv
module tb_qspi_flash_responder;
    localparam int MB = 4096;
    localparam int AW = 24;
    localparam int DC = 8;
    localparam int SBASE = 8 + AW - 1;      // sample index of first single bit
    localparam int QBASE = 8 + AW + DC - 1; // sample index of first quad nibble

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic [3:0]  din = 4'h0;
    logic [3:0]  dout;
    logic        oe;
    logic        we = 1'b0;
    logic [11:0] waddr = 12'h0;
    logic [7:0]  wdata = 8'h0;
    logic        err;

    int total = 0;
    int bad = 0;

    logic [7:0] model [MB];
    logic [3:0] sd [256];
    logic       so [256];
    logic       se [256];
    int         ns;

    qspi_flash_responder #(.MEM_BYTES(MB), .ADDR_W(AW), .DUMMY_CYCLES(DC)) dut (
        .clk_i          (clk),
        .reset_ni       (reset_ni),
        .qspi_sclk_i    (sclk),
        .qspi_cs_ni     (cs_n),
        .qspi_data_i    (din),
        .qspi_data_o    (dout),
        .qspi_data_oe_o (oe),
        .mem_we_i       (we),
        .mem_addr_i     (waddr),
        .mem_wdata_i    (wdata),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bd_write(input int a, input logic [7:0] d);
        we = 1'b1; waddr = 12'(a % MB); wdata = d;
        tick(1);
        we = 1'b0;
        model[a % MB] = d;
    endtask

    // Runs ncyc SCLK cycles with CS low. Each cycle is a rise (3 clk) and
    // then a fall (3 clk). The outputs are sampled at the end of the low
    // phase. An optional backdoor write lands during the high phase of
    // cycle wr_cyc.
    task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr, input int ncyc,
                        input int wr_cyc, input int wr_a, input logic [7:0] wr_d);
        logic [31:0] bits;
        bits = {cmd, addr};
        cs_n = 1'b0;
        tick(3);
        ns = 0;
        for (int i = 0; i < ncyc; i++) begin
            din[0] = (i < 32) ? bits[31 - i] : 1'b0;
            sclk = 1'b1;
            if (i == wr_cyc) begin
                we = 1'b1; waddr = 12'(wr_a % MB); wdata = wr_d;
                tick(1);
                we = 1'b0;
                tick(2);
            end else begin
                tick(3);
            end
            sclk = 1'b0;
            tick(3);
            sd[i] = dout; so[i] = oe; se[i] = err;
            ns = i + 1;
        end
    endtask

    task automatic end_xfer();
        sclk = 1'b0;
        cs_n = 1'b1;
        tick(3);
    endtask

    // Collects the received bytes from the sample buffer. It also reports
    // whether oe was low before the data phase and high during it, and,
    // in single mode, whether the unused IO lines stayed 0.
    task automatic get_stream(input logic q, input int nbytes, output logic [63:0] data,
                              output logic oe_ok, output logic pre_ok, output logic side_ok);
        int base;
        base = q ? QBASE : SBASE;
        data = '0; oe_ok = 1'b1; pre_ok = 1'b1; side_ok = 1'b1;
        for (int i = 0; i < base; i++) if (so[i] !== 1'b0) pre_ok = 1'b0;
        if (q) begin
            for (int k = 0; k < 2 * nbytes; k++) begin
                data = {data[59:0], sd[base + k]};
                if (so[base + k] !== 1'b1) oe_ok = 1'b0;
            end
        end else begin
            for (int k = 0; k < 8 * nbytes; k++) begin
                data = {data[62:0], sd[base + k][1]};
                if (so[base + k] !== 1'b1) oe_ok = 1'b0;
                if ((sd[base + k] & 4'b1101) !== 4'b0000) side_ok = 1'b0;
            end
        end
    endtask

    function automatic logic [63:0] model_bytes(input int a, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = {r[55:0], model[(a + i) % MB]};
        return r;
    endfunction

    task automatic test_reset();
        reset_ni = 1'b0;
        tick(3);
        total++; if (dout !== 4'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0", dout); end
        total++; if (oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", oe); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        reset_ni = 1'b1;
        tick(2);
    endtask

    task automatic test_single_basic();
        logic [63:0] got; logic ook, pok, sok;
        bd_write(0, 8'hA5); bd_write(1, 8'h3C); bd_write(2, 8'h0F); bd_write(3, 8'hF0);
        xfer(8'h03, 24'h000000, SBASE + 32, -1, 0, 8'h0);
        get_stream(1'b0, 4, got, ook, pok, sok);
        total++; if (got[31:0] !== 32'hA53C0FF0) begin bad++; $display("FAIL single_basic_data got=%h exp=A53C0FF0", got[31:0]); end
        total++; if (!(ook && pok)) begin bad++; $display("FAIL single_basic_oe data_ok=%b pre_ok=%b exp=1/1", ook, pok); end
        total++; if (!sok) begin bad++; $display("FAIL single_basic_side unused IO lines nonzero exp=0"); end
        total++; if (se[ns - 1] !== 1'b0) begin bad++; $display("FAIL single_basic_err got=%b exp=0", se[ns - 1]); end
        end_xfer();
    endtask

    task automatic test_single_random();
        logic [63:0] got; logic ook, pok, sok; logic [23:0] a; int n;
        for (int it = 0; it < 5; it++) begin
            a = 24'($urandom);
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) bd_write(int'(a) + i, 8'($urandom));
            xfer(8'h03, a, SBASE + 8 * n, -1, 0, 8'h0);
            get_stream(1'b0, n, got, ook, pok, sok);
            total++;
            if (got !== model_bytes(int'(a), n) || !ook || !pok || !sok) begin
                bad++;
                $display("FAIL single_rand addr=%h got=%h exp=%h oe=%b%b side=%b", a, got, model_bytes(int'(a), n), ook, pok, sok);
            end
            end_xfer();
        end
    endtask

    task automatic test_quad();
        logic [63:0] got; logic ook, pok, sok; logic [23:0] a; int n;
        bd_write(16, 8'h12); bd_write(17, 8'h34);
        xfer(8'h6B, 24'h000010, QBASE + 4, -1, 0, 8'h0);
        get_stream(1'b1, 2, got, ook, pok, sok);
        total++; if (got[15:0] !== 16'h1234) begin bad++; $display("FAIL quad_basic_nibbles got=%h exp=1234", got[15:0]); end
        total++; if (!(ook && pok)) begin bad++; $display("FAIL quad_basic_oe data_ok=%b pre_ok=%b exp=1/1", ook, pok); end
        end_xfer();
        for (int it = 0; it < 4; it++) begin
            a = 24'($urandom);
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) bd_write(int'(a) + i, 8'($urandom));
            xfer(8'h6B, a, QBASE + 2 * n, -1, 0, 8'h0);
            get_stream(1'b1, n, got, ook, pok, sok);
            total++;
            if (got !== model_bytes(int'(a), n) || !ook || !pok) begin
                bad++;
                $display("FAIL quad_rand addr=%h got=%h exp=%h oe=%b%b", a, got, model_bytes(int'(a), n), ook, pok);
            end
            end_xfer();
        end
    endtask

    task automatic test_wrap();
        logic [63:0] got; logic ook, pok, sok;
        bd_write(MB - 1, 8'h77); bd_write(0, 8'h88);
        xfer(8'h03, 24'(MB - 1), SBASE + 16, -1, 0, 8'h0);
        get_stream(1'b0, 2, got, ook, pok, sok);
        total++; if (got[15:0] !== 16'h7788) begin bad++; $display("FAIL wrap_single got=%h exp=7788", got[15:0]); end
        end_xfer();
        xfer(8'h6B, 24'hABC000 | 24'(MB - 1), QBASE + 4, -1, 0, 8'h0);
        get_stream(1'b1, 2, got, ook, pok, sok);
        total++; if (got[15:0] !== 16'h7788) begin bad++; $display("FAIL wrap_quad_highbits got=%h exp=7788", got[15:0]); end
        end_xfer();
    endtask

    task automatic test_bad_cmd();
        logic any_oe;
        xfer(8'h9F, 24'($urandom), 48, -1, 0, 8'h0);
        any_oe = 1'b0;
        for (int i = 0; i < ns; i++) if (so[i] !== 1'b0) any_oe = 1'b1;
        total++; if (any_oe) begin bad++; $display("FAIL badcmd_oe got=1 exp=0 during CS-low window"); end
        total++; if (se[7] !== 1'b1) begin bad++; $display("FAIL badcmd_err got=%b exp=1", se[7]); end
        end_xfer();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL badcmd_sticky got=%b exp=1", err); end
        reset_ni = 1'b0; tick(2); reset_ni = 1'b1; tick(2);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL badcmd_reset_clear got=%b exp=0", err); end
    endtask

    task automatic test_abort();
        logic [63:0] got; logic ook, pok, sok; logic [3:0] nib;
        bd_write(0, 8'hA5); bd_write(1, 8'h3C); bd_write(2, 8'h0F); bd_write(3, 8'hF0);
        xfer(8'h03, 24'h000000, SBASE + 4, -1, 0, 8'h0);
        nib = {sd[SBASE][1], sd[SBASE + 1][1], sd[SBASE + 2][1], sd[SBASE + 3][1]};
        total++; if (nib !== 4'hA) begin bad++; $display("FAIL abort_partial got=%h exp=a", nib); end
        cs_n = 1'b1;
        tick(1);
        total++; if (oe !== 1'b0) begin bad++; $display("FAIL abort_oe_drop got=%b exp=0", oe); end
        tick(2);
        // Abort in the middle of the command byte as well.
        xfer(8'h6B, 24'h0, 5, -1, 0, 8'h0);
        end_xfer();
        xfer(8'h03, 24'h000002, SBASE + 8, -1, 0, 8'h0);
        get_stream(1'b0, 1, got, ook, pok, sok);
        total++; if (got[7:0] !== 8'h0F || !ook || !pok) begin bad++; $display("FAIL abort_reread got=%h exp=0f oe=%b%b", got[7:0], ook, pok); end
        end_xfer();
    endtask

    task automatic test_reset_mid_data();
        logic [63:0] got; logic ook, pok, sok;
        bd_write(0, 8'hA5); bd_write(1, 8'h3C); bd_write(2, 8'h0F); bd_write(3, 8'hF0);
        xfer(8'h03, 24'h000000, SBASE + 12, -1, 0, 8'h0);
        reset_ni = 1'b0;
        tick(1);
        total++; if (dout !== 4'h0) begin bad++; $display("FAIL rstmid_dout got=%h exp=0", dout); end
        total++; if (oe !== 1'b0) begin bad++; $display("FAIL rstmid_oe got=%b exp=0", oe); end
        cs_n = 1'b1; sclk = 1'b0;
        tick(2);
        reset_ni = 1'b1;
        tick(2);
        xfer(8'h03, 24'h000000, SBASE + 32, -1, 0, 8'h0);
        get_stream(1'b0, 4, got, ook, pok, sok);
        total++; if (got[31:0] !== 32'hA53C0FF0 || !ook) begin bad++; $display("FAIL rstmid_reread got=%h exp=A53C0FF0", got[31:0]); end
        end_xfer();
    endtask

    task automatic test_backdoor_during();
        logic [63:0] got; logic ook, pok, sok; logic [7:0] old0, nv; int a;
        a = int'($urandom_range(0, MB - 1));
        bd_write(a, 8'($urandom)); bd_write(a + 1, 8'($urandom));
        old0 = model[a]; nv = ~old0;
        // Byte 0 is already in the shifter by cycle SBASE+2, so it must come out unchanged.
        xfer(8'h03, 24'(a), SBASE + 16, SBASE + 2, a, nv);
        get_stream(1'b0, 2, got, ook, pok, sok);
        total++; if (got[15:0] !== {old0, model[(a + 1) % MB]}) begin bad++; $display("FAIL bd_loaded got=%h exp=%h", got[15:0], {old0, model[(a + 1) % MB]}); end
        end_xfer();
        model[a % MB] = nv;
        nv = ~model[(a + 1) % MB];
        // Byte 1 is not fetched yet, so it must show the new value.
        xfer(8'h03, 24'(a), SBASE + 16, SBASE + 2, a + 1, nv);
        get_stream(1'b0, 2, got, ook, pok, sok);
        total++; if (got[15:0] !== {model[a % MB], nv}) begin bad++; $display("FAIL bd_pending got=%h exp=%h", got[15:0], {model[a % MB], nv}); end
        end_xfer();
        model[(a + 1) % MB] = nv;
    endtask

    initial begin
        for (int i = 0; i < MB; i++) model[i] = 8'h00;
        tick(2);
        test_reset();
        test_single_basic();
        test_single_random();
        test_quad();
        test_wrap();
        test_bad_cmd();
        test_abort();
        test_reset_mid_data();
        test_backdoor_during();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
